// File: rtl/msrv32_ahb_pkg.sv
// msrv32 data-memory responder shared types
// AHB-lite transfer codes, response codes, FSM states
package msrv32_ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } dmem_state_t;

endpackage

// File: rtl/msrv32_dmem_array.sv
// msrv32 data RAM: byte-lane write port, async read port
// Contents are deliberately left unreset
module msrv32_dmem_array
  import msrv32_ahb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // commit enabled byte lanes at the closing edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/msrv32_dmem_responder.sv
// msrv32 data-port responder: decode, wait states, ERROR
// Address phase registered on accept, data phase in DONE
module msrv32_dmem_responder
  import msrv32_ahb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [1:0]  ms_riscv32_mp_data_htrans_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  output logic [31:0] ms_riscv32_mp_data_out,
  output logic        ms_riscv32_mp_data_hready_out,
  output logic        ms_riscv32_mp_hresp_out
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [2:0]  WS   = 3'(WAIT_STATES);

  dmem_state_t   state, state_n;
  htrans_t       ht;
  logic [2:0]    cnt, cnt_n;
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [3:0]    mask_q;
  logic          hready_q, hresp_q;
  logic [31:0]   off;
  logic          in_range, accept;
  logic [3:0]    we;
  logic [31:0]   rdata;

  assign ht       = htrans_t'(ms_riscv32_mp_data_htrans_in);
  assign off      = ms_riscv32_mp_dmaddr_in - BASE_ADDR;
  assign in_range = {1'b0, off} < SPAN;
  assign accept   = hready_q &&
                    (ht == HT_NONSEQ || ht == HT_SEQ);

  // next state; DONE/ERR2 may take a pipelined accept
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_WAIT: begin
        if (cnt == 3'd1) begin
          state_n = S_DONE;
          cnt_n   = 3'd0;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      S_ERR1: state_n = S_ERR2;
      default: begin
        state_n = S_IDLE;
        cnt_n   = 3'd0;
        if (accept) begin
          if (!in_range) begin
            state_n = S_ERR1;
          end else if (WS == 3'd0) begin
            state_n = S_DONE;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WS;
          end
        end
      end
    endcase
  end

  // state, counter, registered response, address phase
  always_ff @(posedge ms_riscv32_mp_clk_in or
              negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      mask_q   <= 4'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hready_q <= state_n inside {S_IDLE, S_DONE, S_ERR2};
      hresp_q  <= (state_n inside {S_ERR1, S_ERR2})
                  ? HRESP_ERROR : HRESP_OKAY;
      if (accept) begin
        idx_q  <= off[AW+1:2];
        wr_q   <= ms_riscv32_mp_dmwr_req_in;
        mask_q <= ms_riscv32_mp_dmwr_mask_in;
      end
    end
  end

  assign we = (state == S_DONE && wr_q) ? mask_q : 4'b0;

  msrv32_dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (ms_riscv32_mp_clk_in),
    .we    (we),
    .waddr (idx_q),
    .wdata (ms_riscv32_mp_dmdata_in),
    .raddr (idx_q),
    .rdata (rdata)
  );

  assign ms_riscv32_mp_data_out =
    (state == S_DONE && !wr_q) ? rdata : 32'h0;
  assign ms_riscv32_mp_data_hready_out = hready_q;
  assign ms_riscv32_mp_hresp_out       = hresp_q;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Directed bench for msrv32_dmem_responder
// Instances: 0 -> 1 wait, 1 -> 0 wait, 2 -> 3 wait
module tb_msrv32_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [3:0]  mask = '0;
  logic [1:0]  tr   [3];
  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        rsp  [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  msrv32_dmem_responder #(
    .WAIT_STATES(1)
  ) u0 (
    .ms_riscv32_mp_clk_in          (clk),
    .ms_riscv32_mp_rst_in          (rst_n),
    .ms_riscv32_mp_dmaddr_in       (addr),
    .ms_riscv32_mp_data_htrans_in  (tr[0]),
    .ms_riscv32_mp_dmwr_req_in     (wr),
    .ms_riscv32_mp_dmwr_mask_in    (mask),
    .ms_riscv32_mp_dmdata_in       (wdata),
    .ms_riscv32_mp_data_out        (dout[0]),
    .ms_riscv32_mp_data_hready_out (rdy[0]),
    .ms_riscv32_mp_hresp_out       (rsp[0])
  );

  msrv32_dmem_responder #(
    .WAIT_STATES(0)
  ) u1 (
    .ms_riscv32_mp_clk_in          (clk),
    .ms_riscv32_mp_rst_in          (rst_n),
    .ms_riscv32_mp_dmaddr_in       (addr),
    .ms_riscv32_mp_data_htrans_in  (tr[1]),
    .ms_riscv32_mp_dmwr_req_in     (wr),
    .ms_riscv32_mp_dmwr_mask_in    (mask),
    .ms_riscv32_mp_dmdata_in       (wdata),
    .ms_riscv32_mp_data_out        (dout[1]),
    .ms_riscv32_mp_data_hready_out (rdy[1]),
    .ms_riscv32_mp_hresp_out       (rsp[1])
  );

  msrv32_dmem_responder #(
    .WAIT_STATES(3)
  ) u2 (
    .ms_riscv32_mp_clk_in          (clk),
    .ms_riscv32_mp_rst_in          (rst_n),
    .ms_riscv32_mp_dmaddr_in       (addr),
    .ms_riscv32_mp_data_htrans_in  (tr[2]),
    .ms_riscv32_mp_dmwr_req_in     (wr),
    .ms_riscv32_mp_dmwr_mask_in    (mask),
    .ms_riscv32_mp_dmdata_in       (wdata),
    .ms_riscv32_mp_data_out        (dout[2]),
    .ms_riscv32_mp_data_hready_out (rdy[2]),
    .ms_riscv32_mp_hresp_out       (rsp[2])
  );

  logic [31:0] rd;
  int          st;
  logic        rf, rdn;

  task automatic xfer(
    input  int          i,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [3:0]  m,
    input  logic [31:0] d,
    output logic [31:0] rdat,
    output int          stall,
    output logic        r_first,
    output logic        r_done
  );
    @(negedge clk);
    addr = a; wr = w; mask = m; wdata = d;
    tr[i] = 2'b10;
    @(negedge clk);
    tr[i] = 2'b00;
    stall = 0;
    r_first = rsp[i];
    while (!rdy[i] && stall < 20) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= 20) stall = 99;
    rdat = dout[i];
    r_done = rsp[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tr[i] = 2'b00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rdy[i] !== 1'b1 || rsp[i] !== 1'b0 ||
          dout[i] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset[%0d]: got rdy=%b rsp=%b d=%h want 1 0 0",
                 i, rdy[i], rsp[i], dout[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, st, rf, rdn);
    vectors++;
    if (st !== 1 || rdn !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wr: got stall=%0d rsp=%b want 1 0", st, rdn);
    end
    xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, st, rf, rdn);
    vectors++;
    if (st !== 1 || rdn !== 1'b0 || rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL basic_rd: got stall=%0d rsp=%b d=%h want 1 0 deadbeef",
               st, rdn, rd);
    end
    @(negedge clk);
    vectors++;
    if (dout[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL idle_dout: got %h want 0", dout[0]);
    end
  endtask

  task automatic test_mask();
    xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd, st, rf, rdn);
    xfer(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd, st, rf, rdn);
    xfer(0, 1'b1, 32'h23, 4'b0000, 32'hFFFFFFFF, rd, st, rf, rdn);
    vectors++;
    if (rdn !== 1'b0) begin
      miscompares++;
      $display("FAIL mask0_resp: got %b want 0", rdn);
    end
    xfer(0, 1'b0, 32'h22, 4'h0, 32'h0, rd, st, rf, rdn);
    vectors++;
    if (rd !== 32'h11BB33DD) begin
      miscompares++;
      $display("FAIL mask_rd: got %h want 11bb33dd", rd);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    addr = 32'h30; wr = 1'b1; mask = 4'hF;
    wdata = 32'h5A5A5A5A; tr[1] = 2'b10;
    @(negedge clk);
    vectors++;
    if (rdy[1] !== 1'b1 || dout[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL b2b_wr: got rdy=%b d=%h want 1 0", rdy[1], dout[1]);
    end
    wr = 1'b0; mask = 4'h0; tr[1] = 2'b11;
    @(negedge clk);
    tr[1] = 2'b00;
    vectors++;
    if (rdy[1] !== 1'b1 || rsp[1] !== 1'b0 ||
        dout[1] !== 32'h5A5A5A5A) begin
      miscompares++;
      $display("FAIL b2b_rd: got rdy=%b rsp=%b d=%h want 1 0 5a5a5a5a",
               rdy[1], rsp[1], dout[1]);
    end
  endtask

  task automatic test_out_of_range();
    xfer(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, rd, st, rf, rdn);
    xfer(0, 1'b1, 32'hFFC, 4'hF, 32'h0BADC0DE, rd, st, rf, rdn);
    xfer(0, 1'b0, 32'hFFC, 4'h0, 32'h0, rd, st, rf, rdn);
    vectors++;
    if (rd !== 32'h0BADC0DE || rdn !== 1'b0) begin
      miscompares++;
      $display("FAIL top_word: got %h rsp=%b want 0badc0de 0", rd, rdn);
    end
    xfer(0, 1'b0, 32'h1000, 4'h0, 32'h0, rd, st, rf, rdn);
    vectors++;
    if (st !== 1 || rf !== 1'b1 || rdn !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL oor_rd: got stall=%0d r1=%b r2=%b d=%h want 1 1 1 0",
               st, rf, rdn, rd);
    end
    xfer(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, rd, st, rf, rdn);
    vectors++;
    if (st !== 1 || rf !== 1'b1 || rdn !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_wr: got stall=%0d r1=%b r2=%b want 1 1 1",
               st, rf, rdn);
    end
    xfer(0, 1'b0, 32'h0, 4'h0, 32'h0, rd, st, rf, rdn);
    vectors++;
    if (rd !== 32'hCAFEF00D || rdn !== 1'b0) begin
      miscompares++;
      $display("FAIL word0: got %h rsp=%b want cafef00d 0", rd, rdn);
    end
  endtask

  task automatic test_idle();
    @(negedge clk);
    addr = 32'h20; wr = 1'b1; mask = 4'hF; wdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      tr[0] = (k == 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      vectors++;
      if (rdy[0] !== 1'b1 || rsp[0] !== 1'b0 || dout[0] !== 32'h0) begin
        miscompares++;
        $display("FAIL idle[%0d]: got rdy=%b rsp=%b d=%h want 1 0 0",
                 k, rdy[0], rsp[0], dout[0]);
      end
    end
    tr[0] = 2'b00;
    xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, rd, st, rf, rdn);
    vectors++;
    if (rd !== 32'h11BB33DD) begin
      miscompares++;
      $display("FAIL idle_mem: got %h want 11bb33dd", rd);
    end
  endtask

  task automatic test_reset_mid();
    xfer(2, 1'b1, 32'h40, 4'hF, 32'h0, rd, st, rf, rdn);
    vectors++;
    if (st !== 3) begin
      miscompares++;
      $display("FAIL ws3_stall: got %0d want 3", st);
    end
    @(negedge clk);
    addr = 32'h40; wr = 1'b1; mask = 4'hF;
    wdata = 32'h12345678; tr[2] = 2'b10;
    @(negedge clk);
    tr[2] = 2'b00;
    vectors++;
    if (rdy[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_wait: got rdy=%b want 0", rdy[2]);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (rdy[2] !== 1'b1 || rsp[2] !== 1'b0 || dout[2] !== 32'h0) begin
      miscompares++;
      $display("FAIL async_rst: got rdy=%b rsp=%b d=%h want 1 0 0",
               rdy[2], rsp[2], dout[2]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(2, 1'b0, 32'h40, 4'h0, 32'h0, rd, st, rf, rdn);
    vectors++;
    if (rd !== 32'h0 || st !== 3) begin
      miscompares++;
      $display("FAIL rst_nowrite: got %h stall=%0d want 0 3", rd, st);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tr[i] = 2'b00;
    test_reset();
    test_basic();
    test_mask();
    test_back_to_back();
    test_out_of_range();
    test_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msrv32_dmem_responder.md
# msrv32_dmem_responder

Memory-side responder for the msrv32 core's data port: it accepts the core's AHB-lite-style data requests (address, write request, byte mask, transfer type), stores and serves 32-bit words with a configurable number of wait states, and flags out-of-range accesses with a two-cycle ERROR response. It sits between the core's data interface and the testbench/SoC memory map, serving as the data RAM in simulation and FPGA builds.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, minimum 4.
- WAIT_STATES, 1: data-phase stall cycles, 0..7.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- ms_riscv32_mp_clk_in  in  1  clock, rising edge.
- ms_riscv32_mp_rst_in  in  1  reset, asynchronous, active-low.
- ms_riscv32_mp_dmaddr_in  in  32  byte address, address phase.
- ms_riscv32_mp_data_htrans_in  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- ms_riscv32_mp_dmwr_req_in  in  1  1 = write, 0 = read; address phase.
- ms_riscv32_mp_dmwr_mask_in  in  4  byte-lane write enables; address phase.
- ms_riscv32_mp_dmdata_in  in  32  write data, data phase.
- ms_riscv32_mp_data_out  out  32  read data, valid on read completion.
- ms_riscv32_mp_data_hready_out  out  1  transfer done / ready for address.
- ms_riscv32_mp_hresp_out  out  1  0 OKAY, 1 ERROR.

## Operation
- Transfer accepted when htrans[1]=1 and hready_out=1 at a rising edge. Address, wr_req and mask are registered.
- IDLE/BUSY requests are not transfers. They get a zero-wait OKAY response, and the memory is not touched.
- In range means BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*4. Word index = (addr-BASE_ADDR)[.. :2]. addr[1:0] is ignored.
- Write: on the completion cycle, byte i of mem[idx] is updated from dmdata_in[8i+7:8i] where mask[i]=1, at that cycle's closing edge. Mask 0000 completes OKAY with no change.
- Read: data_out = mem[idx] during the completion cycle, and 0 in all other cycles.
- Out of range, read or write: no memory access, and the response is ERROR.
- Memory contents are not reset; their initial value is X.
- FSM states:
  - IDLE: hready=1, hresp=0.
  - WAIT: hready=0, hresp=0, counter counting down.
  - DONE: hready=1, hresp=0, completion cycle.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- FSM transitions:
  - Accept in range: WAIT_STATES=0 goes to DONE, otherwise to WAIT with count = WAIT_STATES.
  - WAIT: decrement; go to DONE when the count reaches 1.
  - Accept out of range: go to ERR1, then ERR2.
  - DONE or ERR2: a new accepted transfer in the same cycle (pipelined address phase) follows the accept rules; otherwise go to IDLE.
  - Address-phase signals are ignored in WAIT and ERR1.

## Timing
- Reset values: hready_out=1, hresp_out=0, data_out=0, FSM=IDLE, counter=0.
- In-range latency: the completion cycle is WAIT_STATES+1 cycles after the accept edge.
- Error latency: ERR1 is 1 cycle after accept, ERR2 is 2 cycles after.
- Back-to-back throughput: one transfer per WAIT_STATES+1 cycles.
- A read whose address phase overlaps the completion cycle of a write to the same word returns the new data, because the write commits before the read's completion.
- Reset asserted mid-transfer: the transfer is abandoned, no write commits, and outputs return to reset values immediately (asynchronously).
- hready_out and hresp_out are driven from registers. data_out is combinational from the registered index.

## Structure
- Package msrv32_ahb_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP_OKAY / HRESP_ERROR constants.
  - dmem_state_t enum.
- Sub-module msrv32_dmem_array: a byte-lane-writable word RAM with one write port, plus one asynchronous read port.
- The top contains the FSM, wait counter, address decode and registered address-phase fields.

## Test plan
- Reset, WAIT_STATES=1: write 0xDEADBEEF, mask 1111, addr 0x10, then read 0x10. Expect hready low for 1 cycle on each transfer; the read returns 0xDEADBEEF with hresp=0.
- Byte mask: write 0x11223344 (mask 1111) then 0xAABBCCDD (mask 0101) to addr 0x20. A read returns 0x11BB33DD.
- WAIT_STATES=0, pipelined write addr 0x30 (0x5A5A5A5A) followed immediately by a read of 0x30. Expect no stall cycles, and the read returns 0x5A5A5A5A.
- Out of range, DEPTH_WORDS=1024: read addr 0x1000. Expect hready=0/hresp=1 then hready=1/hresp=1, and data_out=0. A following write to 0x1000 leaves word 0 unchanged.
- htrans=00 with wr_req=1 for 5 cycles: hready stays 1, hresp stays 0, and memory is unchanged.
- Reset asserted in WAIT (WAIT_STATES=3) of a write to 0x40 holding 0x0: outputs go to reset values at once, and a later read of 0x40 returns 0x0.
